// File: rtl/vscale_hasti_sram_ws.sv
// HASTI (AHB-Lite) SRAM slave with configurable wait states, base-address
// decode and two-cycle ERROR responses for illegal transfers.
module vscale_hasti_sram_ws #(
   parameter int unsigned NWORDS      = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic        hmastlock,
   input  logic [3:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic        hresp
);

   localparam int unsigned IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ERR1 = 2'd2,
      S_ERR2 = 2'd3
   } state_t;

   // Address-phase controls captured on accept, used during the data phase.
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
      logic [1:0]       off;
      logic [2:0]       size;
      logic             write;
      logic             err;
   } xfer_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   xfer_t              xfer, xfer_nx;

   logic [31:0]        mem [NWORDS];

   logic [31:0]        offset_c;
   logic [29:0]        word_c;
   logic               err_c;
   logic               accept_c;
   logic               commit_c;
   logic               rd_active_c;
   logic [3:0]         mask_c;
   logic               unused_c;

   // Bus attributes this slave does not act on.
   assign unused_c = ^{hburst, hmastlock, hprot, offset_c[1:0]};

   // Address decode and legality check for the address phase on the bus.
   always_comb begin
      offset_c = haddr - BASE_ADDR;
      word_c   = offset_c[31:2];
      err_c    = 1'b0;
      if (haddr < BASE_ADDR)                        err_c = 1'b1;
      if (word_c >= 30'(NWORDS))                    err_c = 1'b1;
      if (hsize > 3'd2)                             err_c = 1'b1;
      if ((hsize == 3'd1) && haddr[0])              err_c = 1'b1;
      if ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) err_c = 1'b1;
   end

   // Slave ready/response are pure decodes of the registered state.
   assign hready   = (state == S_IDLE) || (state == S_ERR2);
   assign hresp    = (state == S_ERR1) || (state == S_ERR2);
   assign accept_c = hready && htrans[1];

   // State, wait counter and captured transfer registers.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state <= S_IDLE;
         cnt   <= '0;
         xfer  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         xfer  <= xfer_nx;
      end
   end

   // Next-state logic: accept new transfers whenever hready is high.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      xfer_nx  = xfer;
      case (state)
         S_IDLE, S_ERR2: begin
            state_nx = S_IDLE;
            if (accept_c) begin
               xfer_nx.valid = 1'b1;
               xfer_nx.idx   = word_c[IDX_W-1:0];
               xfer_nx.off   = haddr[1:0];
               xfer_nx.size  = hsize;
               xfer_nx.write = hwrite;
               xfer_nx.err   = err_c;
               if (err_c) begin
                  state_nx = S_ERR1;
               end else if (WAIT_STATES != 0) begin
                  state_nx = S_WAIT;
                  cnt_nx   = CNT_W'(WAIT_STATES - 1);
               end
            end else begin
               xfer_nx.valid = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt == '0) begin
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         S_ERR1: begin
            state_nx = S_ERR2;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // A write lands on the edge closing its (non-errored) data phase.
   assign commit_c = (state == S_IDLE) && xfer.valid && xfer.write && !xfer.err;

   // Byte-lane enables from the captured size and byte offset.
   always_comb begin
      mask_c = 4'h0;
      case (xfer.size)
         3'd0:    mask_c = 4'b0001 << xfer.off;
         3'd1:    mask_c = 4'b0011 << xfer.off;
         default: mask_c = 4'hF;
      endcase
   end

   // Memory array; contents survive reset.
   always_ff @(posedge hclk) begin
      if (commit_c) begin
         for (int i = 0; i < 4; i++) begin
            if (mask_c[i]) begin
               mem[xfer.idx][8*i +: 8] <= hwdata[8*i +: 8];
            end
         end
      end
   end

   // Read data is driven for every cycle of a legal read data phase only.
   assign rd_active_c = xfer.valid && !xfer.write && !xfer.err;
   assign hrdata      = rd_active_c ? mem[xfer.idx] : 32'h0;

endmodule

// File: tb/tb_vscale_hasti_sram_ws.sv
// Scoreboard bench: two slave instances (zero-wait at address 0, and
// three-wait at 0x1000 with 16 words), randomized and directed traffic.
module tb_vscale_hasti_sram_ws;

   localparam int unsigned N0 = 64;
   localparam int unsigned N1 = 16;
   localparam int unsigned W0 = 0;
   localparam int unsigned W1 = 3;
   localparam logic [31:0] B0 = 32'h0;
   localparam logic [31:0] B1 = 32'h1000;

   typedef struct {
      int          kind;   // 1 = okay transfer, 2 = error
      logic [31:0] data;   // expected hrdata (0 for writes)
   } exp_t;

   logic              hclk = 1'b0;
   logic [1:0]        hreset;
   logic [1:0][31:0]  haddr;
   logic [1:0]        hwrite;
   logic [1:0][2:0]   hsize;
   logic [1:0][2:0]   hburst;
   logic [1:0]        hmastlock;
   logic [1:0][3:0]   hprot;
   logic [1:0][1:0]   htrans;
   logic [1:0][31:0]  hwdata;
   logic [1:0][31:0]  hrdata;
   logic [1:0]        hready;
   logic [1:0]        hresp;

   int          n_chk  = 0;
   int          n_fail = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] mdl [2][64];
   logic [31:0] pend_wd [2];
   bit          mon_en [2];
   int          cur_kind [2];
   logic [31:0] cur_data [2];
   int          cur_c [2];

   always #5 hclk = ~hclk;

   vscale_hasti_sram_ws #(.NWORDS(N0), .WAIT_STATES(W0), .BASE_ADDR(B0)) u_dut0 (
      .hclk(hclk), .hreset(hreset[0]), .haddr(haddr[0]), .hwrite(hwrite[0]),
      .hsize(hsize[0]), .hburst(hburst[0]), .hmastlock(hmastlock[0]),
      .hprot(hprot[0]), .htrans(htrans[0]), .hwdata(hwdata[0]),
      .hrdata(hrdata[0]), .hready(hready[0]), .hresp(hresp[0]));

   vscale_hasti_sram_ws #(.NWORDS(N1), .WAIT_STATES(W1), .BASE_ADDR(B1)) u_dut1 (
      .hclk(hclk), .hreset(hreset[1]), .haddr(haddr[1]), .hwrite(hwrite[1]),
      .hsize(hsize[1]), .hburst(hburst[1]), .hmastlock(hmastlock[1]),
      .hprot(hprot[1]), .htrans(htrans[1]), .hwdata(hwdata[1]),
      .hrdata(hrdata[1]), .hready(hready[1]), .hresp(hresp[1]));

   function automatic logic [31:0] base_of(input int i);
      return (i == 0) ? B0 : B1;
   endfunction

   function automatic int nw_of(input int i);
      return (i == 0) ? int'(N0) : int'(N1);
   endfunction

   function automatic int ws_of(input int i);
      return (i == 0) ? int'(W0) : int'(W1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: legality and memory effect from the bus rules, then
   // drive one address phase and hold it until the slave takes it.
   task automatic issue(input int i, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [1:0] tr, input logic [31:0] wd);
      exp_t        e;
      bit          err;
      int          idx;
      int          lane;
      int          t;
      logic [31:0] rel;
      if (tr[1]) begin
         rel = a - base_of(i);
         err = (a < base_of(i)) || ((rel >> 2) >= 32'(nw_of(i))) || (sz > 3'd2) ||
               (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
         e.kind = err ? 2 : 1;
         e.data = 32'h0;
         if (!err) begin
            idx = int'(rel >> 2);
            if (w) begin
               for (int b = 0; b < (1 << sz); b++) begin
                  lane = int'(a[1:0]) + b;
                  mdl[i][idx][8*lane +: 8] = wd[8*lane +: 8];
               end
            end else begin
               e.data = mdl[i][idx];
            end
         end
         if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
      haddr[i]  = a;
      hwrite[i] = w;
      hsize[i]  = sz;
      htrans[i] = tr;
      hwdata[i] = pend_wd[i];
      for (t = 0; t < 64; t++) begin
         @(negedge hclk);
         if (hready[i]) break;
      end
      if (t == 64) chk($sformatf("i%0d_ready_timeout", i), 32'd0, 32'd1);
      @(posedge hclk);
      #1;
      pend_wd[i] = wd;
   endtask

   // Monitor: compares every data-phase cycle against the expected shape.
   always @(negedge hclk) begin
      for (int i = 0; i < 2; i++) begin
         int          len;
         logic        e_rdy;
         logic        e_resp;
         logic [31:0] e_rd;
         exp_t        e;
         if (hreset[i] || !mon_en[i]) begin
            cur_kind[i] = 0;
            cur_c[i]    = 0;
            continue;
         end
         len    = (cur_kind[i] == 0) ? 1 : (cur_kind[i] == 2) ? 2 : ws_of(i) + 1;
         e_rdy  = (cur_c[i] == len - 1);
         e_resp = (cur_kind[i] == 2);
         e_rd   = (cur_kind[i] == 1) ? cur_data[i] : 32'h0;
         chk($sformatf("i%0d_hready", i), 32'(hready[i]), 32'(e_rdy));
         chk($sformatf("i%0d_hresp", i),  32'(hresp[i]),  32'(e_resp));
         chk($sformatf("i%0d_hrdata", i), hrdata[i], e_rd);
         if (e_rdy) begin
            cur_c[i]    = 0;
            cur_kind[i] = 0;
            if (htrans[i][1]) begin
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  chk($sformatf("i%0d_sb_empty", i), 32'd0, 32'd1);
               end else begin
                  e = (i == 0) ? q0.pop_front() : q1.pop_front();
                  cur_kind[i] = e.kind;
                  cur_data[i] = e.data;
               end
            end
         end else begin
            cur_c[i]++;
         end
      end
   end

   task automatic rand_xfer(input int i, input logic [31:0] lo, input logic [31:0] hi);
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  tr;
      a  = lo + $urandom_range(0, hi - lo);
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      if (($urandom_range(0, 3) != 0) && (sz != 3'd0)) a[1:0] = 2'b00;
      tr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      issue(i, a, 1'($urandom_range(0, 1)), sz, tr, $urandom);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 64; k++) mdl[i][k] = 32'h0;
         pend_wd[i] = 32'h0;
         mon_en[i]  = 1'b0;
      end
      hreset    = 2'b11;
      haddr     = '0;
      hwrite    = '0;
      hsize     = '0;
      hburst    = '0;
      hmastlock = '0;
      hprot     = '0;
      htrans    = '0;
      hwdata    = '0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("i%0d_rst_hready", i), 32'(hready[i]), 32'd1);
         chk($sformatf("i%0d_rst_hresp", i),  32'(hresp[i]),  32'd0);
         chk($sformatf("i%0d_rst_hrdata", i), hrdata[i], 32'h0);
      end
      repeat (2) @(posedge hclk);
      #1;
      hreset    = 2'b00;
      mon_en[0] = 1'b1;
      mon_en[1] = 1'b1;

      // Instance 0: zero-wait, base 0, 64 words.
      for (int k = 0; k < int'(N0); k++) issue(0, 32'(4 * k), 1'b1, 3'd2, 2'd2, 32'h0);
      issue(0, 32'h10, 1'b1, 3'd2, 2'd2, 32'hDEADBEEF);
      issue(0, 32'h10, 1'b0, 3'd2, 2'd2, 32'h0);
      issue(0, 32'h23, 1'b1, 3'd0, 2'd2, 32'hAA000000);
      issue(0, 32'h20, 1'b1, 3'd1, 2'd2, 32'h00001234);
      issue(0, 32'h20, 1'b0, 3'd2, 2'd3, 32'h0);
      issue(0, 32'h20, 1'b1, 3'd2, 2'd0, 32'hFFFFFFFF);
      issue(0, 32'h20, 1'b1, 3'd2, 2'd1, 32'hFFFFFFFF);
      issue(0, 32'h20, 1'b0, 3'd2, 2'd2, 32'h0);
      issue(0, 32'h100, 1'b1, 3'd2, 2'd2, 32'h55555555);
      issue(0, 32'h12, 1'b1, 3'd2, 2'd2, 32'h66666666);
      issue(0, 32'h10, 1'b0, 3'd2, 2'd2, 32'h0);
      for (int k = 0; k < 300; k++) rand_xfer(0, 32'h0, 32'(4 * N0 + 15));
      for (int k = 0; k < int'(N0); k++) issue(0, 32'(4 * k), 1'b0, 3'd2, 2'd2, 32'h0);
      issue(0, 32'h0, 1'b0, 3'd0, 2'd0, 32'h0);

      // Instance 1: three wait states, base 0x1000, 16 words.
      for (int k = 0; k < int'(N1); k++) issue(1, B1 + 32'(4 * k), 1'b1, 3'd2, 2'd2, 32'h0);
      issue(1, 32'h1004, 1'b1, 3'd2, 2'd2, 32'h0BADF00D);
      issue(1, 32'h1040, 1'b1, 3'd2, 2'd2, 32'h12121212);
      issue(1, 32'h0FFC, 1'b1, 3'd2, 2'd2, 32'h34343434);
      issue(1, 32'h1001, 1'b1, 3'd1, 2'd2, 32'h56565656);
      issue(1, 32'h1004, 1'b1, 3'd3, 2'd2, 32'h78787878);
      issue(1, 32'h1000, 1'b0, 3'd3, 2'd2, 32'h0);
      issue(1, 32'h1004, 1'b0, 3'd2, 2'd2, 32'h0);
      issue(1, 32'h1000, 1'b0, 3'd2, 2'd2, 32'h0);
      for (int k = 0; k < 80; k++) rand_xfer(1, 32'h0FF0, 32'h1050);
      for (int k = 0; k < int'(N1); k++) issue(1, B1 + 32'(4 * k), 1'b0, 3'd2, 2'd2, 32'h0);

      // Reset during the wait states of a write must abandon it.
      issue(1, 32'h1008, 1'b1, 3'd2, 2'd2, 32'h11111111);
      issue(1, 32'h1008, 1'b0, 3'd2, 2'd2, 32'h0);
      issue(1, 32'h0, 1'b0, 3'd0, 2'd0, 32'h0);
      mon_en[1] = 1'b0;
      haddr[1]  = 32'h1008;
      hwrite[1] = 1'b1;
      hsize[1]  = 3'd2;
      htrans[1] = 2'd2;
      @(posedge hclk);
      #1;
      hwdata[1] = 32'hCAFEF00D;
      htrans[1] = 2'd0;
      hwrite[1] = 1'b0;
      chk("i1_wait_hready", 32'(hready[1]), 32'd0);
      @(posedge hclk);
      #1;
      chk("i1_wait2_hready", 32'(hready[1]), 32'd0);
      hreset[1] = 1'b1;
      #1;
      chk("i1_abort_hready", 32'(hready[1]), 32'd1);
      chk("i1_abort_hresp",  32'(hresp[1]),  32'd0);
      chk("i1_abort_hrdata", hrdata[1], 32'h0);
      @(posedge hclk);
      #1;
      hreset[1]  = 1'b0;
      pend_wd[1] = 32'h0;
      mon_en[1]  = 1'b1;
      issue(1, 32'h1008, 1'b0, 3'd2, 2'd2, 32'h0);
      issue(1, 32'h0, 1'b0, 3'd0, 2'd0, 32'h0);

      repeat (8) @(posedge hclk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
